// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller and its load/store clients.
// Holds the controller state encoding and the load/store length codes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  // Code 2 has no transfer size of its own and is folded into a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      LEN_BYTE: byte_count = 3'd1;
      LEN_HALF: byte_count = 3'd2;
      LEN_WORD: byte_count = 3'd4;
      default:  byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a load/store port.
// Memory read data arrives one cycle after its address; rdy low freezes the whole block.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [31:0] addr,
  output logic        wr
);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  n_bytes;
  logic        owner_ls;
  logic [31:0] shreg;
  logic [31:0] addr_q;
  logic [7:0]  dout_q;
  logic        wr_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_rdata_q;
  logic [31:0] assembled;
  logic [5:0]  shamt;
  logic        rd_last;
  logic        rd_more;
  logic        wr_last;

  always_comb begin
    rd_last   = (cnt == n_bytes);
    rd_more   = (cnt < n_bytes - 3'd1);
    wr_last   = (cnt == n_bytes - 3'd1);
    shamt     = {3'd4 - n_bytes, 3'b000};
    assembled = {din, shreg[31:8]} >> shamt;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ls_req)      state_nxt = ls_wr ? WR : RD;
        else if (if_req) state_nxt = RD;
      end
      RD:      if (rd_last) state_nxt = DONE;
      WR:      if (wr_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  // RD runs one cycle past the last address because each byte lands on din a cycle late;
  // incoming bytes shift in from the top and are right-aligned when the last one arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      n_bytes    <= '0;
      owner_ls   <= 1'b0;
      shreg      <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ls_req) begin
            owner_ls <= 1'b1;
            n_bytes  <= byte_count(ls_len);
            addr_q   <= ls_addr;
            shreg    <= ls_wr ? ls_wdata : 32'd0;
            dout_q   <= ls_wr ? ls_wdata[7:0] : 8'd0;
            wr_q     <= ls_wr;
          end else if (if_req) begin
            owner_ls <= 1'b0;
            n_bytes  <= 3'd4;
            addr_q   <= if_addr;
            shreg    <= '0;
          end
        end
        RD: begin
          cnt    <= cnt + 3'd1;
          addr_q <= rd_more ? addr_q + 32'd1 : 32'd0;
          if (cnt != 3'd0) shreg <= {din, shreg[31:8]};
          if (rd_last) begin
            if (owner_ls) ls_rdata_q <= assembled;
            else          if_data_q  <= assembled;
          end
        end
        WR: begin
          cnt <= cnt + 3'd1;
          if (wr_last) begin
            addr_q <= '0;
            dout_q <= '0;
            wr_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + 32'd1;
            dout_q <= shreg[15:8];
            shreg  <= shreg >> 8;
          end
        end
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  assign addr     = addr_q;
  assign dout     = dout_q;
  assign wr       = wr_q & rdy;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;
  assign if_done  = (state == DONE) && !owner_ls && rdy;
  assign ls_done  = (state == DONE) &&  owner_ls && rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide memory model, per-cycle reference model of the bus
// and completion timing, plus hand-computed expectations for each scenario.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_len;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  din = 8'd0;
  logic [7:0]  dout;
  logic [31:0] addr;
  logic        wr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_30000 = 0;

  logic [7:0] mem [logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .din(din), .dout(dout), .addr(addr), .wr(wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0010: rom = 8'h13;
      32'h0000_0011: rom = 8'h05;
      32'h0000_0200: rom = 8'h11;
      32'h0000_0201: rom = 8'h22;
      32'h0000_0202: rom = 8'h33;
      32'h0000_0203: rom = 8'h44;
      32'h0003_0000: rom = 8'h5A;
      32'hFFFF_FFFF: rom = 8'hAB;
      32'h0000_0000: rom = 8'hCD;
      default:       rom = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : rom(a);
  endfunction

  // Memory answers one cycle after the address and, like the controller, pauses with rdy.
  always @(posedge clk) begin
    if (rdy) begin
      din <= mem_rd(addr);
      if (!wr && addr == 32'h0003_0000) rd_30000 <= rd_30000 + 1;
    end
    if (wr === 1'b1) mem[addr] = dout;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: position q counts rdy-high cycles since acceptance.
  logic        m_busy = 1'b0;
  logic        m_ls, m_wr;
  logic [31:0] m_a, m_wd, m_exp_rd, m_tmp;
  int          m_n, m_q, m_end;
  logic [31:0] m_if_data = '0;
  logic [31:0] m_ls_rdata = '0;
  logic        e_wr, e_ifd, e_lsd;

  always @(negedge clk) begin
    if (rst) begin
      m_busy     = 1'b0;
      m_if_data  = '0;
      m_ls_rdata = '0;
      check_output("rst_addr", addr, 32'd0);
      check_output("rst_dout", {24'd0, dout}, 32'd0);
      check_output("rst_wr", {31'd0, wr}, 32'd0);
      check_output("rst_if_done", {31'd0, if_done}, 32'd0);
      check_output("rst_ls_done", {31'd0, ls_done}, 32'd0);
      check_output("rst_if_data", if_data, 32'd0);
      check_output("rst_ls_rdata", ls_rdata, 32'd0);
    end else begin
      e_wr = 1'b0; e_ifd = 1'b0; e_lsd = 1'b0;
      if (m_busy) begin
        if (m_q >= 1 && m_q <= m_n) begin
          check_output("bus_addr", addr, m_a + 32'(m_q - 1));
          if (m_wr) begin
            e_wr  = rdy;
            m_tmp = m_wd >> (8 * (m_q - 1));
            check_output("bus_dout", {24'd0, dout}, {24'd0, m_tmp[7:0]});
          end
        end
        if (m_q == m_end && rdy) begin
          if (m_ls) begin
            e_lsd = 1'b1;
            if (!m_wr) m_ls_rdata = m_exp_rd;
          end else begin
            e_ifd = 1'b1;
            m_if_data = m_exp_rd;
          end
        end
      end else begin
        check_output("idle_addr", addr, 32'd0);
        check_output("idle_dout", {24'd0, dout}, 32'd0);
      end
      check_output("wr", {31'd0, wr}, {31'd0, e_wr});
      check_output("if_done", {31'd0, if_done}, {31'd0, e_ifd});
      check_output("ls_done", {31'd0, ls_done}, {31'd0, e_lsd});
      if (!(m_busy && m_q == m_end && !rdy)) begin
        check_output("if_data", if_data, m_if_data);
        check_output("ls_rdata", ls_rdata, m_ls_rdata);
      end
      if (m_busy) begin
        if (rdy) begin
          if (m_q == m_end) m_busy = 1'b0;
          else              m_q++;
        end
      end else if (rdy && (ls_req || if_req)) begin
        m_busy = 1'b1;
        m_q    = 1;
        m_ls   = ls_req;
        if (ls_req) begin
          m_wr = ls_wr;
          m_a  = ls_addr;
          m_wd = ls_wdata;
          m_n  = (ls_len == 2'd0) ? 1 : (ls_len == 2'd1) ? 2 : 4;
        end else begin
          m_wr = 1'b0;
          m_a  = if_addr;
          m_wd = '0;
          m_n  = 4;
        end
        m_end    = m_wr ? m_n + 1 : m_n + 2;
        m_exp_rd = '0;
        for (int i = 0; i < m_n; i++)
          m_exp_rd = m_exp_rd | (32'(mem_rd(m_a + 32'(i))) << (8 * i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit is_ls, input bit is_wr, input logic [31:0] a,
                                input logic [1:0] len, input logic [31:0] wd);
    if (is_ls) begin
      ls_req = 1'b1; ls_wr = is_wr; ls_addr = a; ls_len = len; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
  endtask

  task automatic wait_done(input bit is_ls, output int dc);
    bit found;
    found = 1'b0;
    dc = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ((is_ls ? ls_done : if_done) === 1'b1) begin
        found = 1'b1;
        dc = cyc;
      end
    end
    if (!found) check_output("done_timeout", 32'd0, 32'd1);
  endtask

  int c, d, d2;

  initial begin
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_len = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_addr", addr, 32'd0);
    check_output("reset_wr", {31'd0, wr}, 32'd0);
    check_output("reset_if_data", if_data, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] word fetch at 0x10");
    apply_stimulus(0, 0, 32'h10, 2'd0, 32'd0);
    c = cyc;
    wait_done(0, d);
    check_output("if_latency", 32'(d - c), 32'd6);
    check_output("if_word", if_data, 32'h0000_0513);
    tick(); if_req = 1'b0; tick();

    $display("[TB] word store 0xDEADBEEF at 0x100");
    apply_stimulus(1, 1, 32'h100, 2'd3, 32'hDEAD_BEEF);
    c = cyc;
    wait_done(1, d);
    check_output("st_latency", 32'(d - c), 32'd5);
    check_output("st_wr_at_done", {31'd0, wr}, 32'd0);
    tick(); ls_req = 1'b0;
    check_output("st_wr_after", {31'd0, wr}, 32'd0);
    check_output("st_mem", {mem_rd(32'h103), mem_rd(32'h102), mem_rd(32'h101), mem_rd(32'h100)},
                 32'hDEAD_BEEF);
    tick();

    $display("[TB] simultaneous fetch and byte load");
    apply_stimulus(0, 0, 32'h10, 2'd0, 32'd0);
    apply_stimulus(1, 0, 32'h0003_0000, 2'd0, 32'd0);
    c = cyc;
    wait_done(1, d);
    check_output("arb_ls_latency", 32'(d - c), 32'd3);
    check_output("arb_ls_rdata", ls_rdata, 32'h0000_005A);
    tick(); ls_req = 1'b0;
    wait_done(0, d2);
    check_output("arb_if_after_ls", 32'(d2 - d), 32'd7);
    check_output("arb_if_data", if_data, 32'h0000_0513);
    check_output("arb_single_read", 32'(rd_30000), 32'd1);
    tick(); if_req = 1'b0; tick();

    $display("[TB] word fetch with 3-cycle pause");
    apply_stimulus(0, 0, 32'h200, 2'd0, 32'd0);
    c = cyc;
    tick(); tick(); tick();
    rdy = 1'b0;
    @(negedge clk);
    check_output("pause_addr_a", addr, 32'h202);
    check_output("pause_wr", {31'd0, wr}, 32'd0);
    tick(); tick();
    @(negedge clk);
    check_output("pause_addr_b", addr, 32'h202);
    tick();
    rdy = 1'b1;
    wait_done(0, d);
    check_output("pause_latency", 32'(d - c), 32'd9);
    check_output("pause_data", if_data, 32'h4433_2211);
    tick(); if_req = 1'b0; tick();

    $display("[TB] reset during store");
    apply_stimulus(1, 1, 32'h400, 2'd3, 32'hCAFE_F00D);
    tick(); tick(); tick();
    check_output("rst_mid_addr", addr, 32'h402);
    check_output("rst_mid_wr", {31'd0, wr}, 32'd1);
    #1;
    rst = 1'b1; ls_req = 1'b0;
    #1;
    check_output("rst_now_wr", {31'd0, wr}, 32'd0);
    check_output("rst_now_addr", addr, 32'd0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_output("rst_no_done", {31'd0, ls_done}, 32'd0);
    end
    check_output("rst_partial", {mem_rd(32'h402), mem_rd(32'h401), mem_rd(32'h400)},
                 32'h0000_F00D);
    tick();
    apply_stimulus(1, 0, 32'h401, 2'd0, 32'd0);
    c = cyc;
    wait_done(1, d);
    check_output("rst_reload_latency", 32'(d - c), 32'd3);
    check_output("rst_reload_data", ls_rdata, 32'h0000_00F0);
    tick(); ls_req = 1'b0; tick();

    $display("[TB] halfword load across the address wrap");
    apply_stimulus(1, 0, 32'hFFFF_FFFF, 2'd1, 32'd0);
    c = cyc;
    wait_done(1, d);
    check_output("wrap_latency", 32'(d - c), 32'd4);
    check_output("wrap_rdata", ls_rdata, 32'h0000_CDAB);
    tick(); ls_req = 1'b0; tick();

    $display("[TB] length code 2 loads a word");
    apply_stimulus(1, 0, 32'h200, 2'd2, 32'd0);
    c = cyc;
    wait_done(1, d);
    check_output("len2_latency", 32'(d - c), 32'd6);
    check_output("len2_rdata", ls_rdata, 32'h4433_2211);
    tick(); ls_req = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as the codebase names them: clk and rst.
REQ-002 The port list SHALL be, clock and reset first:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  pause when low
- if_req  in  1  instruction fetch request
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle fetch completion pulse
- if_data  out  32  fetched word
- ls_req  in  1  load/store request
- ls_wr  in  1  1 = store, 0 = load
- ls_addr  in  32  load/store address
- ls_len  in  2  byte count minus one; legal values 0, 1, 3
- ls_wdata  in  32  store data, little-endian
- ls_done  out  1  one-cycle load/store completion pulse
- ls_rdata  out  32  load data, zero-extended
- din  in  8  memory read byte
- dout  out  8  memory write byte
- addr  out  32  memory byte address
- wr  out  1  1 = write

Function
REQ-003 The state machine SHALL have four states: IDLE, RD, WR and DONE.
REQ-004 In IDLE with rdy high, a pending ls_req SHALL win over a pending if_req; an if_req is served only when ls_req is low.
REQ-005 On acceptance in cycle c, the block SHALL latch the address, byte count N (4 for IF, ls_len+1 for LS), write data and owner.
- Load or fetch: go to RD.
- Store: go to WR.
REQ-006 In RD, addr SHALL present A, A+1, … A+N-1 in cycles c+1 … c+N, with wr=0.
REQ-007 In RD, din SHALL be captured at the end of cycles c+2 … c+N+1 into byte lanes 0 … N-1.
REQ-008 For reads, the done pulse and valid data SHALL appear in cycle c+N+2.
- Word read latency: 6 cycles from acceptance.
REQ-009 In WR, cycles c+1 … c+N SHALL drive addr=A+i, dout=ls_wdata byte i, wr=1.
REQ-010 For stores, ls_done SHALL pulse in cycle c+N+1, with wr=0 in that cycle.
REQ-011 DONE SHALL last exactly one cycle, drive only the owner's done signal, accept no request, and then return to IDLE.
- Next acceptance: earliest one cycle after the done pulse.
REQ-012 Requesters SHALL hold req and operands stable until done; changes mid-transaction are ignored.
REQ-013 ls_rdata bits above 8·N SHALL be zero.
REQ-014 if_data and ls_rdata SHALL hold their values until that port's next completion.
REQ-015 When idle, addr SHALL be 0, wr SHALL be 0 and dout SHALL be 0.
REQ-016 Address increments SHALL wrap modulo 2^32; no alignment checks are made.
REQ-017 Each byte SHALL be accessed exactly once per transaction, so reads at 0x30000 and above are never repeated.
REQ-018 While rdy is low, every register SHALL hold its value and the wr output SHALL be forced to 0.
- Resume: continue at the exact cycle position.
- rdy-low cycles add to latency one-for-one.
REQ-019 ls_len=2 SHALL be treated as 3.

Reset
REQ-020 When rst is asserted, the block SHALL at once enter IDLE with every output 0, clearing addr, dout, wr, both done signals, if_data, ls_rdata, counters and latched operands.
REQ-021 A reset during a transaction SHALL abandon it with no done pulse; partial writes already issued stay in memory.

Structure
REQ-022 A shared package SHALL hold the state encoding and the ls_len codes (BYTE=0, HALF=1, WORD=3), for reuse by the load/store unit.
REQ-023 The block SHALL be one flat module: registered state, byte counter, 32-bit shift/assemble register and output registers, with no sub-module.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- IF word at 0x00000010, memory bytes 0x13,0x05,0x00,0x00 -> addr 0x10 to 0x13 over 4 cycles; if_done in cycle c+6; if_data=0x00000513.
- LS store word 0xDEADBEEF to 0x100 -> wr=1 for 4 cycles, bytes EF,BE,AD,DE at 0x100 to 0x103; ls_done in cycle c+5; wr=0 after.
- if_req and ls_req (byte load at 0x30000) in the same cycle -> LS served first, single read of 0x30000, ls_rdata=0x000000xx; IF accepted one cycle after ls_done.
- rdy low for 3 cycles in the middle of a word read -> addr, counter and captured bytes frozen; wr=0; correct data; latency 6+3.
- rst asserted during the third byte of a store -> immediate IDLE, wr=0, no ls_done; a new load after reset completes normally.
- Halfword load at 0xFFFFFFFF -> addresses 0xFFFFFFFF then 0x00000000 (wrap); ls_rdata[31:16]=0.
